// File: rtl/simd_alu_pipe.sv
// Multi-lane SIMD ALU behind a two-stage valid/ready pipeline.
// S1 captures the operation; S2 holds per-lane results and flags that drive the outputs.
module simd_alu_pipe #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             ctrl,
   input  logic [LANES-1:0]       lane_mask,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] res,
   output logic [LANES-1:0]       is_zero,
   output logic [LANES-1:0]       is_negative,
   output logic [LANES-1:0]       is_equal,
   output logic [LANES-1:0]       is_gt,
   output logic [LANES-1:0]       is_lt,
   output logic [LANES-1:0]       is_ovf
);

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             neg;
      logic             eq;
      logic             gt;
      logic             lt;
      logic             ovf;
   } lane_out_t;

   function automatic lane_out_t lane_alu(input logic [3:0]              op,
                                          input logic signed [WIDTH-1:0] x,
                                          input logic signed [WIDTH-1:0] y);
      lane_out_t      o;
      logic [SHW-1:0] sh;
      logic           defined;
      o       = '0;
      sh      = y[SHW-1:0];
      defined = 1'b1;
      case (op)
         4'd0: begin
            o.res = x + y;
            o.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
         end
         4'd1: begin
            o.res = x - y;
            o.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (o.res[WIDTH-1] != x[WIDTH-1]);
         end
         4'd2:    o.res = x << sh;
         4'd3:    o.res = x >> sh;
         4'd4:    o.res = x & y;
         4'd5:    o.res = x | y;
         4'd6:    o.res = x ^ y;
         4'd7:    o.res = ~(x & y);
         4'd8:    o.res = ~x;
         4'd9:    o.res = ~(x | y);
         4'd10:   o.res = x >>> sh;
         4'd11:   o.res = (x < y) ? x : y;
         4'd12:   o.res = (x > y) ? x : y;
         default: defined = 1'b0;
      endcase
      // Reserved opcodes leave the whole lane record at zero, compare flags included.
      if (defined) begin
         o.zero = (o.res == '0);
         o.neg  = o.res[WIDTH-1];
         o.eq   = (x == y);
         o.gt   = (x > y);
         o.lt   = (x < y);
      end
      return o;
   endfunction

   logic                   s1_load, s2_load;
   logic                   vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
   logic [3:0]             ctrl_p1_d, ctrl_p1_q;
   logic [LANES-1:0]       mask_p1_d, mask_p1_q;
   logic [LANES*WIDTH-1:0] a_p1_d, a_p1_q, b_p1_d, b_p1_q;
   logic [LANES*WIDTH-1:0] res_p2_d, res_p2_q;
   logic [LANES-1:0]       zero_p2_d, zero_p2_q, neg_p2_d, neg_p2_q, eq_p2_d, eq_p2_q;
   logic [LANES-1:0]       gt_p2_d, gt_p2_q, lt_p2_d, lt_p2_q, ovf_p2_d, ovf_p2_q;
   lane_out_t              lane_o;

   assign s2_load  = !vld_p2_q || out_ready;
   assign s1_load  = !vld_p1_q || s2_load;
   assign in_ready = s1_load;

   // Stage S1: capture the accepted operation
   always_comb begin
      vld_p1_d  = vld_p1_q;
      ctrl_p1_d = ctrl_p1_q;
      mask_p1_d = mask_p1_q;
      a_p1_d    = a_p1_q;
      b_p1_d    = b_p1_q;
      if (s1_load) begin
         vld_p1_d = in_valid;
         if (in_valid) begin
            ctrl_p1_d = ctrl;
            mask_p1_d = lane_mask;
            a_p1_d    = a;
            b_p1_d    = b;
         end
      end
   end

   // Stage S2: per-lane compute into the output registers
   always_comb begin
      vld_p2_d  = s2_load ? vld_p1_q : vld_p2_q;
      res_p2_d  = res_p2_q;
      zero_p2_d = zero_p2_q;
      neg_p2_d  = neg_p2_q;
      eq_p2_d   = eq_p2_q;
      gt_p2_d   = gt_p2_q;
      lt_p2_d   = lt_p2_q;
      ovf_p2_d  = ovf_p2_q;
      lane_o    = '0;
      if (s2_load && vld_p1_q) begin
         for (int i = 0; i < LANES; i++) begin
            lane_o = lane_alu(ctrl_p1_q, a_p1_q[i*WIDTH +: WIDTH], b_p1_q[i*WIDTH +: WIDTH]);
            if (!mask_p1_q[i]) lane_o = '0;
            res_p2_d[i*WIDTH +: WIDTH] = lane_o.res;
            zero_p2_d[i] = lane_o.zero;
            neg_p2_d[i]  = lane_o.neg;
            eq_p2_d[i]   = lane_o.eq;
            gt_p2_d[i]   = lane_o.gt;
            lt_p2_d[i]   = lane_o.lt;
            ovf_p2_d[i]  = lane_o.ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      ctrl_p1_q <= ctrl_p1_d;
      mask_p1_q <= mask_p1_d;
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         res_p2_q  <= '0;
         zero_p2_q <= '0;
         neg_p2_q  <= '0;
         eq_p2_q   <= '0;
         gt_p2_q   <= '0;
         lt_p2_q   <= '0;
         ovf_p2_q  <= '0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         vld_p2_q  <= vld_p2_d;
         res_p2_q  <= res_p2_d;
         zero_p2_q <= zero_p2_d;
         neg_p2_q  <= neg_p2_d;
         eq_p2_q   <= eq_p2_d;
         gt_p2_q   <= gt_p2_d;
         lt_p2_q   <= lt_p2_d;
         ovf_p2_q  <= ovf_p2_d;
      end
   end

   assign out_valid   = vld_p2_q;
   assign res         = res_p2_q;
   assign is_zero     = zero_p2_q;
   assign is_negative = neg_p2_q;
   assign is_equal    = eq_p2_q;
   assign is_gt       = gt_p2_q;
   assign is_lt       = lt_p2_q;
   assign is_ovf      = ovf_p2_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe: hand-derived vector table plus a model-fed scoreboard,
// with backpressure, full-rate and mid-flight reset sequences.
module tb_simd_alu_pipe;
   localparam int W = 32;
   localparam int L = 4;

   logic           clk = 1'b0;
   logic           rst, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]     ctrl;
   logic [L-1:0]   lane_mask;
   logic [L*W-1:0] a, b, res;
   logic [L-1:0]   is_zero, is_negative, is_equal, is_gt, is_lt, is_ovf;

   simd_alu_pipe #(.WIDTH(W), .LANES(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl(ctrl), .lane_mask(lane_mask), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .res(res),
      .is_zero(is_zero), .is_negative(is_negative), .is_equal(is_equal),
      .is_gt(is_gt), .is_lt(is_lt), .is_ovf(is_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] res;
      logic [3:0]   z, n, eq, gt, lt, ov;
   } exp_t;

   typedef struct {
      string        name;
      logic [3:0]   c;
      logic [3:0]   m;
      logic [127:0] a, b;
      exp_t         e;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   exp_t        q[$];
   logic [31:0] got_l0[$];
   int          n_out = 0;
   bit          saw_full = 1'b0;
   bit          rec_l0 = 1'b0;
   vec_t        tbl[12];

   function automatic exp_t cur_out();
      return {res, is_zero, is_negative, is_equal, is_gt, is_lt, is_ovf};
   endfunction

   function automatic exp_t mk(input logic [127:0] r, input logic [3:0] z, n, eq, gt, lt, ov);
      exp_t e;
      e.res = r; e.z = z; e.n = n; e.eq = eq; e.gt = gt; e.lt = lt; e.ov = ov;
      return e;
   endfunction

   // Reference model: 64-bit arithmetic, overflow from widened result
   function automatic exp_t model(input logic [3:0] c, input logic [3:0] m,
                                  input logic [127:0] aa, input logic [127:0] bb);
      exp_t        e;
      logic [31:0] x, y, r;
      longint      sx, sy, full;
      logic        ov;
      e = '0;
      for (int i = 0; i < L; i++) begin
         x = aa[i*32 +: 32];
         y = bb[i*32 +: 32];
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         r = 32'd0; ov = 1'b0; full = 0;
         if (!m[i] || c > 4'd12) continue;
         case (c)
            4'd0:  begin full = sx + sy; r = full[31:0]; ov = (full != longint'($signed(r))); end
            4'd1:  begin full = sx - sy; r = full[31:0]; ov = (full != longint'($signed(r))); end
            4'd2:  r = x << y[4:0];
            4'd3:  r = x >> y[4:0];
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = x ^ y;
            4'd7:  r = ~(x & y);
            4'd8:  r = ~x;
            4'd9:  r = ~(x | y);
            4'd10: begin full = sx >>> y[4:0]; r = full[31:0]; end
            4'd11: r = (sx < sy) ? x : y;
            default: r = (sx > sy) ? x : y;
         endcase
         e.res[i*32 +: 32] = r;
         e.z[i]  = (r == 32'd0);
         e.n[i]  = r[31];
         e.eq[i] = (sx == sy);
         e.gt[i] = (sx > sy);
         e.lt[i] = (sx < sy);
         e.ov[i] = ov;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic monitor_loop();
      logic [152:0] prev_snap;
      bit           stall_prev;
      exp_t         e;
      stall_prev = 1'b0;
      prev_snap  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            stall_prev = 1'b0;
            continue;
         end
         if (stall_prev) chk("stall_hold", 160'({out_valid, cur_out()}), 160'(prev_snap));
         if (out_valid && out_ready) begin
            n_out++;
            if (rec_l0) got_l0.push_back(res[31:0]);
            if (q.size() == 0) begin
               chk("unexpected_out", 160'(cur_out()), 160'(0));
            end else begin
               e = q.pop_front();
               chk("scoreboard", 160'(cur_out()), 160'(e));
            end
         end
         if (in_valid && in_ready) q.push_back(model(ctrl, lane_mask, a, b));
         if (!in_ready) saw_full = 1'b1;
         stall_prev = out_valid && !out_ready;
         prev_snap  = {out_valid, cur_out()};
      end
   endtask

   task automatic send(input logic [3:0] c, input logic [3:0] m,
                       input logic [127:0] aa, input logic [127:0] bb);
      int k;
      ctrl = c; lane_mask = m; a = aa; b = bb; in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("accept", 160'(in_ready), 160'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((out_valid || q.size() != 0) && k < 40);
      chk(nm, 160'({out_valid, 32'(q.size())}), 160'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] j_a, j_b, mm_a, mm_b, bw_a, bw_b;
      int bad_ready, bad_valid, n0;

      rst = 1'b1; in_valid = 1'b0; ctrl = 4'd0; lane_mask = '0; a = '0; b = '0; out_ready = 1'b1;

      j_a  = {32'hDEADBEEF, 32'hCAFEF00D, 32'h00000000, 32'h80000010};
      j_b  = {32'h00000001, 32'h00000002, 32'h00000003, 32'h00000024};
      mm_a = {32'h0BADF00D, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD};
      mm_b = {32'h00000009, 32'h80000000, 32'h00000004, 32'h00000007};
      bw_a = {32'hF0F0F0F0, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
      bw_b = {32'h0F0F0F0F, 32'h00000000, 32'h80000000, 32'h12345678};

      tbl[0]  = '{"add_ovf", 4'd0, 4'b0011,
                  {32'h11111111, 32'h22222222, 32'h00000005, 32'h7FFFFFFF},
                  {32'h00000003, 32'h00000004, 32'hFFFFFFFB, 32'h00000001},
                  mk({96'h0, 32'h80000000}, 4'b0010, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0001)};
      tbl[1]  = '{"sll", 4'd2, 4'b0001, j_a, j_b,
                  mk({96'h0, 32'h00000100}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000)};
      tbl[2]  = '{"srl", 4'd3, 4'b0001, j_a, j_b,
                  mk({96'h0, 32'h08000001}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000)};
      tbl[3]  = '{"sra", 4'd10, 4'b0001, j_a, j_b,
                  mk({96'h0, 32'hF8000001}, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000)};
      tbl[4]  = '{"min", 4'd11, 4'b0001, mm_a, mm_b,
                  mk({96'h0, 32'hFFFFFFFD}, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000)};
      tbl[5]  = '{"max", 4'd12, 4'b0001, mm_a, mm_b,
                  mk({96'h0, 32'h00000007}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000)};
      tbl[6]  = '{"reserved14", 4'd14, 4'b1111, bw_a, bw_b, '0};
      tbl[7]  = '{"and", 4'd4, 4'b1111, bw_a, bw_b,
                  mk({32'h0, 32'h0, 32'h80000000, 32'h12345678},
                     4'b1100, 4'b0010, 4'b0101, 4'b0010, 4'b1000, 4'b0000)};
      tbl[8]  = '{"xor", 4'd6, 4'b1111, bw_a, bw_b,
                  mk({32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0},
                     4'b0101, 4'b1000, 4'b0101, 4'b0010, 4'b1000, 4'b0000)};
      tbl[9]  = '{"nor", 4'd9, 4'b1111, bw_a, bw_b,
                  mk({32'h0, 32'hFFFFFFFF, 32'h0, 32'hEDCBA987},
                     4'b1010, 4'b0101, 4'b0101, 4'b0010, 4'b1000, 4'b0000)};
      tbl[10] = '{"sub_ovf", 4'd1, 4'b0001, {96'h0, 32'h80000000}, {96'h0, 32'h00000001},
                  mk({96'h0, 32'h7FFFFFFF}, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001)};
      tbl[11] = '{"mask_off", 4'd0, 4'b0000, bw_a, bw_b, '0};

      fork
         monitor_loop();
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", 160'({out_valid, cur_out()}), 160'(0));
      chk("reset_in_ready", 160'(in_ready), 160'(1));
      @(posedge clk);
      #1;

      for (int t = 0; t < 12; t++) begin
         ctrl = tbl[t].c; lane_mask = tbl[t].m; a = tbl[t].a; b = tbl[t].b; in_valid = 1'b1;
         @(negedge clk);
         chk({tbl[t].name, "_in_ready"}, 160'(in_ready), 160'(1));
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         chk({tbl[t].name, "_lat1"}, 160'(out_valid), 160'(0));
         @(posedge clk);
         @(negedge clk);
         chk({tbl[t].name, "_lat2"}, 160'(out_valid), 160'(1));
         chk(tbl[t].name, 160'(cur_out()), 160'(tbl[t].e));
         @(posedge clk);
         #1;
      end
      wait_drain("table_drain");

      // Backpressure: 8 back-to-back ADDs with a 5-cycle downstream stall
      @(posedge clk);
      #1;
      got_l0.delete(); n_out = 0; saw_full = 1'b0; rec_l0 = 1'b1;
      fork
         for (int i = 0; i < 8; i++) send(4'd0, 4'hF, {4{32'(i)}}, {4{32'd100}});
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain("bp_drain");
      rec_l0 = 1'b0;
      chk("bp_count", 160'(n_out), 160'(8));
      chk("bp_full_seen", 160'(saw_full), 160'(1));
      for (int i = 0; i < got_l0.size() && i < 8; i++)
         chk("bp_order", 160'(got_l0[i]), 160'(100 + i));

      // Full-rate: 16 back-to-back mixed operations
      @(posedge clk);
      #1;
      n_out = 0; bad_ready = 0; bad_valid = 0;
      fork
         for (int i = 0; i < 16; i++)
            send(4'(i % 13), 4'($urandom_range(1, 15)),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
         for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c < 16 && !in_ready) bad_ready++;
            if (c >= 2 && !out_valid) bad_valid++;
         end
      join
      wait_drain("tput_drain");
      chk("tput_in_ready", 160'(bad_ready), 160'(0));
      chk("tput_out_valid", 160'(bad_valid), 160'(0));
      chk("tput_count", 160'(n_out), 160'(16));

      // Reset with two operations in flight and the output stalled
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(4'd0, 4'hF, {4{32'd1}}, {4{32'd2}});
      send(4'd1, 4'hF, {4{32'd9}}, {4{32'd3}});
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_out", 160'({out_valid, cur_out()}), 160'(0));
      chk("rst_mid_in_ready", 160'(in_ready), 160'(1));
      @(posedge clk);
      #1 out_ready = 1'b1;
      n0 = n_out;
      repeat (8) @(negedge clk);
      chk("rst_no_stale", 160'(n_out - n0), 160'(0));
      @(posedge clk);
      #1;
      send(4'd5, 4'b0101, {4{32'h00F0}}, {4{32'h0F00}});
      wait_drain("post_rst_drain");
      chk("post_rst_count", 160'(n_out - n0), 160'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
